// File: rtl/char_feeder.sv
// char_feeder: byte FIFO that feeds a downstream character matcher.
// Each entry carries a byte plus an end-of-string flag. The module also tracks
// the zero-based position of the head byte within its string, and keeps a
// sticky flag for pushes that were dropped because the FIFO was full.
//
// Optional feature: define CHAR_FEEDER_CASE_FOLD_EN to fold lowercase ASCII
// ('a'..'z') to uppercase on out_char. Stored data is never modified.

module char_feeder #(
    parameter int DEPTH = 8,
    parameter int POS_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_char,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [7:0]               out_char,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [POS_W-1:0]         pos,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage: {last, char} per entry. Not reset; contents are don't-care while empty.
    logic [8:0]     mem_q [DEPTH];

    logic [AW-1:0]  wrPtr_q, wrPtr_d;
    logic [AW-1:0]  rdPtr_q, rdPtr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic           overflow_q, overflow_d;

    logic           isFull;
    logic           isEmpty;
    logic           doPush;
    logic           doPop;
    logic [8:0]     headEntry;

    assign isFull    = (count_q == CW'(DEPTH));
    assign isEmpty   = (count_q == '0);
    assign headEntry = mem_q[rdPtr_q];

    // Handshakes are decided from registered state only, so a full FIFO never
    // accepts a push even if a pop happens on the same edge.
    assign doPush = in_valid && !isFull && !reset;
    assign doPop  = out_ready && !isEmpty && !reset;

    assign in_ready  = !isFull;
    assign out_valid = !isEmpty;
    assign out_last  = headEntry[8];
    assign pos       = pos_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

`ifdef CHAR_FEEDER_CASE_FOLD_EN
    // Fold lowercase ASCII letters to uppercase on the way out.
    always_comb begin
        out_char = headEntry[7:0];
        if (headEntry[7:0] >= 8'h61 && headEntry[7:0] <= 8'h7A) begin
            out_char = headEntry[7:0] - 8'h20;
        end
    end
`else
    // Present the stored head byte unchanged.
    always_comb begin
        out_char = headEntry[7:0];
    end
`endif

    // Next-state computation for pointers, occupancy, position and overflow.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        pos_d      = pos_q;
        overflow_d = overflow_q;

        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end

        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
            if (headEntry[8]) begin
                pos_d = '0;
            end else begin
                pos_d = pos_q + POS_W'(1);
            end
        end

        unique case ({doPush, doPop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (in_valid && isFull) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            pos_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            pos_q      <= pos_d;
            overflow_q <= overflow_d;
        end
    end

    // Write the pushed entry at the tail.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= {in_last, in_char};
        end
    end

endmodule

// File: tb/tb_char_feeder.sv
// tb_char_feeder: self-checking bench for char_feeder.
// Covers the table-driven "ABC" string, fill/overflow/drain, steady push+pop
// across pointer wrap, asynchronous reset mid-operation, the case-fold option
// and position wrap on a narrow counter, then a randomized run checked
// against a queue-based reference model.

module tb_char_feeder;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [7:0]  inChar;
    logic        inValid;
    logic        inLast;
    logic        inReady;
    logic [7:0]  outChar;
    logic        outValid;
    logic        outLast;
    logic        outReady;
    logic [15:0] pos;
    logic [3:0]  count;
    logic        overflow;

    logic [7:0]  in4Char;
    logic        in4Valid;
    logic        in4Last;
    logic        in4Ready;
    logic [7:0]  out4Char;
    logic        out4Valid;
    logic        out4Last;
    logic        out4Ready;
    logic [3:0]  pos4;
    logic [3:0]  count4;
    logic        overflow4;

    int checks;
    int failures;

    // Reference model: queue of {last, char} entries, position and sticky flag.
    logic [8:0] mq[$];
    int         mPos;
    bit         mOvf;

    typedef struct {
        bit         inValid;
        logic [7:0] inChar;
        bit         inLast;
        bit         outReady;
        bit         expValid;
        logic [7:0] expChar;
        bit         expLast;
        int         expCount;
        int         expPos;
    } vec_t;

    vec_t vecs[4];

    char_feeder #(.DEPTH(DEPTH), .POS_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_char  (inChar),
        .in_valid (inValid),
        .in_last  (inLast),
        .in_ready (inReady),
        .out_char (outChar),
        .out_valid(outValid),
        .out_last (outLast),
        .out_ready(outReady),
        .pos      (pos),
        .count    (count),
        .overflow (overflow)
    );

    char_feeder #(.DEPTH(DEPTH), .POS_W(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .in_char  (in4Char),
        .in_valid (in4Valid),
        .in_last  (in4Last),
        .in_ready (in4Ready),
        .out_char (out4Char),
        .out_valid(out4Valid),
        .out_last (out4Last),
        .out_ready(out4Ready),
        .pos      (pos4),
        .count    (count4),
        .overflow (overflow4)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected presentation of a stored byte, depending on the build option.
    function automatic logic [7:0] foldChar(input logic [7:0] b);
`ifdef CHAR_FEEDER_CASE_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkOutput(input string tag);
        checkVal({tag, " out_valid"}, int'(outValid), int'(mq.size() != 0));
        checkVal({tag, " count"},     int'(count),    mq.size());
        checkVal({tag, " in_ready"},  int'(inReady),  int'(mq.size() != DEPTH));
        checkVal({tag, " overflow"},  int'(overflow), int'(mOvf));
        checkVal({tag, " pos"},       int'(pos),      mPos);
        if (mq.size() != 0) begin
            checkVal({tag, " out_char"}, int'(outChar), int'(foldChar(mq[0][7:0])));
            checkVal({tag, " out_last"}, int'(outLast), int'(mq[0][8]));
        end
    endtask

    // Drive one cycle of inputs, advance the model by one edge, sample at +1.
    task automatic applyStimulus(input bit v, input logic [7:0] c, input bit l, input bit r);
        bit doPush;
        bit doPop;
        bit dropped;
        logic [8:0] head;
        inValid  = v;
        inChar   = c;
        inLast   = l;
        outReady = r;
        doPush  = v && (mq.size() < DEPTH);
        doPop   = r && (mq.size() > 0);
        dropped = v && (mq.size() == DEPTH);
        @(posedge clk);
        if (doPop) begin
            head = mq.pop_front();
            mPos = head[8] ? 0 : (mPos + 1) % 65536;
        end
        if (doPush) mq.push_back({l, c});
        if (dropped) mOvf = 1'b1;
        #1;
        inValid  = 1'b0;
        outReady = 1'b0;
    endtask

    // Pulse reset between edges and clear the model.
    task automatic doReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        mq.delete();
        mPos = 0;
        mOvf = 1'b0;
    endtask

    initial begin
        int popIdx;
        checks   = 0;
        failures = 0;
        mPos     = 0;
        mOvf     = 1'b0;
        reset    = 1'b1;
        inChar   = 8'h00;
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b0;
        in4Char  = 8'h00;
        in4Valid = 1'b0;
        in4Last  = 1'b0;
        out4Ready = 1'b0;

        // Reset state, checked before any clock edge.
        #3;
        checkVal("reset out_valid", int'(outValid), 0);
        checkVal("reset in_ready",  int'(inReady),  1);
        checkVal("reset count",     int'(count),    0);
        checkVal("reset pos",       int'(pos),      0);
        checkVal("reset overflow",  int'(overflow), 0);
        #9;
        reset = 1'b0;

        // "ABC" string with the consumer always ready.
        vecs[0] = '{1, 8'h41, 0, 1, 1, 8'h41, 0, 1, 0};
        vecs[1] = '{1, 8'h42, 0, 1, 1, 8'h42, 0, 1, 1};
        vecs[2] = '{1, 8'h43, 1, 1, 1, 8'h43, 1, 1, 2};
        vecs[3] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].inValid, vecs[i].inChar, vecs[i].inLast, vecs[i].outReady);
            checkVal($sformatf("abc[%0d] out_valid", i), int'(outValid), int'(vecs[i].expValid));
            checkVal($sformatf("abc[%0d] count", i),     int'(count),    vecs[i].expCount);
            checkVal($sformatf("abc[%0d] pos", i),       int'(pos),      vecs[i].expPos);
            if (vecs[i].expValid) begin
                checkVal($sformatf("abc[%0d] out_char", i), int'(outChar), int'(vecs[i].expChar));
                checkVal($sformatf("abc[%0d] out_last", i), int'(outLast), int'(vecs[i].expLast));
            end
        end

        // Fill to full, drop a ninth push, then drain in order.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'h41 + 8'(i), 0, 0);
        checkVal("fill count", int'(count), 8);
        checkVal("fill in_ready", int'(inReady), 0);
        applyStimulus(1, 8'h49, 0, 0);
        checkVal("drop overflow", int'(overflow), 1);
        checkVal("drop count", int'(count), 8);
        for (int i = 0; i < 8; i++) begin
            checkVal($sformatf("drain[%0d] out_char", i), int'(outChar), 8'h41 + i);
            applyStimulus(0, 8'h00, 0, 1);
        end
        checkVal("drain count", int'(count), 0);
        checkVal("drain out_valid", int'(outValid), 0);
        checkVal("drain overflow sticky", int'(overflow), 1);

        // Steady state at count 4 with push and pop every cycle across wrap.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h30 + 8'(i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 8'h34 + 8'(i), 0, 1);
            checkVal($sformatf("steady[%0d] count", i), int'(count), 4);
            checkVal($sformatf("steady[%0d] out_char", i), int'(outChar), 8'h31 + i);
        end

        // Asynchronous reset between edges with count 5, pos 3.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'h50 + 8'(i), 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 0, 1);
        checkVal("pre-reset count", int'(count), 5);
        checkVal("pre-reset pos", int'(pos), 3);
        reset = 1'b1;
        #2;
        checkVal("async reset count", int'(count), 0);
        checkVal("async reset pos", int'(pos), 0);
        checkVal("async reset out_valid", int'(outValid), 0);
        checkVal("async reset overflow", int'(overflow), 0);
        checkVal("async reset in_ready", int'(inReady), 1);
        reset = 1'b0;
        mq.delete();
        mPos = 0;
        mOvf = 1'b0;

        // Case folding of lowercase letters; punctuation passes untouched.
        applyStimulus(1, 8'h61, 0, 0);
`ifdef CHAR_FEEDER_CASE_FOLD_EN
        checkVal("fold 'a'", int'(outChar), 8'h41);
`else
        checkVal("fold 'a'", int'(outChar), 8'h61);
`endif
        applyStimulus(1, 8'h5B, 1, 1);
        checkVal("fold '['", int'(outChar), 8'h5B);
        checkOutput("fold");
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("fold drained");

        // Narrow position counter wraps after 16 bytes of one string.
        doReset();
        popIdx = 0;
        for (int k = 0; k < 19; k++) begin
            in4Valid  = (k < 17);
            in4Char   = 8'(k);
            in4Last   = 1'b0;
            out4Ready = 1'b1;
            @(posedge clk);
            #1;
            if (out4Valid) begin
                checkVal($sformatf("pos4[%0d]", popIdx), int'(pos4), popIdx % 16);
                popIdx++;
            end
        end
        in4Valid  = 1'b0;
        out4Ready = 1'b0;
        checkVal("pos4 byte total", popIdx, 17);
        checkVal("pos4 final count", int'(count4), 0);

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit r;
            if (i < 200) begin
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 2) == 0);
            end else begin
                v = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            applyStimulus(v, 8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0), r);
            checkOutput($sformatf("rand[%0d]", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_feeder.md
CHAR_FEEDER -- requirements
Module: char_feeder

Interface
- REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
- REQ-002 SHALL have parameter POS_W, default 16, width of the position counter.
- REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
- REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
- REQ-005 SHALL have port in_char  input  8  byte offered by the host.
- REQ-006 SHALL have port in_valid  input  1  host push request.
- REQ-007 SHALL have port in_last  input  1  marks in_char as the final byte of the current string.
- REQ-008 SHALL have port in_ready  output  1  high when FIFO not full.
- REQ-009 SHALL have port out_char  output  8  byte presented to the downstream char matcher testChar.
- REQ-010 SHALL have port out_valid  output  1  head entry present.
- REQ-011 SHALL have port out_last  output  1  last flag of head entry.
- REQ-012 SHALL have port out_ready  input  1  downstream consume, driven from matcher rdy.
- REQ-013 SHALL have port pos  output  POS_W  zero-based index of out_char within the current string.
- REQ-014 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
- REQ-015 SHALL have port overflow  output  1  sticky dropped-push flag.

Function
- REQ-016 Push SHALL occur on a clk edge when in_valid=1 and in_ready=1; {in_last,in_char} stored at tail.
- REQ-017 Pop SHALL occur on a clk edge when out_valid=1 and out_ready=1; head entry discarded.
- REQ-018 in_ready SHALL equal (count != DEPTH), combinational from state only; no same-cycle pop credit when full.
- REQ-019 out_valid SHALL equal (count != 0); out_char/out_last SHALL reflect the head entry combinationally from storage.
- REQ-020 Push-to-out_valid latency SHALL be one cycle; a byte pushed into an empty FIFO is never visible or poppable in its push cycle.
- REQ-021 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
- REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
- REQ-023 out_ready while out_valid=0 SHALL have no effect.
- REQ-024 in_valid=1 while count==DEPTH SHALL drop the byte, leave contents unchanged, and set overflow=1 on that edge.
- REQ-025 overflow SHALL remain 1 until reset.
- REQ-026 pos SHALL increment by 1 on each pop of an entry with last=0, wrapping modulo 2^POS_W.
- REQ-027 pos SHALL return to 0 on pop of an entry with last=1, so the next byte starts a new string at index 0.
- REQ-028 out_char, out_last, pos SHALL be stable while out_valid=1 and out_ready=0.

Reset
- REQ-029 Asserting reset SHALL immediately, independent of clk, clear pointers, count=0, pos=0, overflow=0, giving out_valid=0, in_ready=1.
- REQ-030 Reset mid-string SHALL discard all stored bytes; no push or pop SHALL occur on any edge while reset=1.
- REQ-031 Storage array contents need not be reset; out_char/out_last SHALL be don't-care while out_valid=0.

Configuration
- REQ-032 Macro CHAR_FEEDER_CASE_FOLD_EN SHALL select case folding.
- REQ-033 With CHAR_FEEDER_CASE_FOLD_EN defined, out_char SHALL equal head byte minus 0x20 when head byte is 0x61..0x7A, else head byte unchanged; stored data is unmodified.
- REQ-034 Without CHAR_FEEDER_CASE_FOLD_EN, out_char SHALL equal the stored head byte exactly; all other behaviour identical.

Verification
- REQ-035 Reset, push "ABC" (last on 'C'), out_ready=1 -> out_char A,B,C on consecutive cycles starting one cycle after first push, pos 0,1,2, then pos=0, count=0.
- REQ-036 out_ready=0, push 8 bytes 0x41..0x48 -> count=8, in_ready=0; 9th push 0x49 -> overflow=1, count=8; drain -> 0x41..0x48 in order, 0x49 absent.
- REQ-037 count=4, push and pop every cycle for 20 cycles -> count stays 4, output order equals input order across pointer wrap.
- REQ-038 Reset asserted between clk edges with count=5, pos=3 -> count=0, pos=0, out_valid=0, overflow=0 before next edge.
- REQ-039 Push 'a' (0x61) -> out_char 0x41 with CHAR_FEEDER_CASE_FOLD_EN defined, 0x61 without; '[' (0x5B) -> 0x5B in both builds.
- REQ-040 POS_W=4, push 17 bytes with last=0 and drain -> pos sequence 0..15,0.
